// File: rtl/regf_byte_unloader.sv
// Captures {Y,X} on load and streams it MSB byte first over valid/ready; dout_valid rises 1 cycle after load.
// Holds dout/byte_idx while valid&!ready; optional GAP idle cycles after each accepted byte; hex digits for byte and bytes left.
module regf_byte_unloader #(
  parameter int GAP    = 0,
  parameter int NBYTES = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] X,
  input  logic [31:0] Y,
  output logic [7:0]  dout,
  output logic        dout_valid,
  input  logic        dout_ready,
  output logic        busy,
  output logic        done,
  output logic [2:0]  byte_idx,
  output logic [6:0]  _7seg0,
  output logic [6:0]  _7seg1,
  output logic [6:0]  _7seg2
);

  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_GAP} state_t;

  localparam logic [3:0] GAP_W    = 4'(GAP);
  localparam logic [2:0] LAST_IDX = 3'(NBYTES - 1);

  state_t      r_state;
  logic [63:0] r_sreg;
  logic        r_valid;
  logic        r_busy;
  logic        r_done;
  logic [2:0]  r_idx;
  logic [3:0]  r_gap;
  logic [3:0]  w_rem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_sreg  <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_idx   <= '0;
      r_gap   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (load) begin
            r_sreg  <= {Y, X};
            r_idx   <= '0;
            r_valid <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (dout_ready) begin
            r_idx <= r_idx + 3'd1;
            // The final byte is not shifted out so dout keeps showing it while idle.
            if (r_idx == LAST_IDX) begin
              r_valid <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= ST_IDLE;
            end else begin
              r_sreg <= {r_sreg[55:0], 8'h00};
              if (GAP_W != 4'd0) begin
                r_valid <= 1'b0;
                r_gap   <= GAP_W;
                r_state <= ST_GAP;
              end
            end
          end
        end
        ST_GAP: begin
          r_gap <= r_gap - 4'd1;
          if (r_gap == 4'd1) begin
            r_valid <= 1'b1;
            r_state <= ST_SEND;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign dout       = r_sreg[63:56];
  assign dout_valid = r_valid;
  assign busy       = r_busy;
  assign done       = r_done;
  assign byte_idx   = r_idx;
  assign w_rem      = r_busy ? (4'd8 - {1'b0, r_idx}) : 4'd0;

  hex7seg u_seg0 (.i_hex(dout[3:0]), .o_seg(_7seg0));
  hex7seg u_seg1 (.i_hex(dout[7:4]), .o_seg(_7seg1));
  hex7seg u_seg2 (.i_hex(w_rem),     .o_seg(_7seg2));

endmodule

// Hex digit to 7-segment, active-high, bit order {g,f,e,d,c,b,a}.
module hex7seg (
  input  logic [3:0] i_hex,
  output logic [6:0] o_seg
);
  always_comb begin
    o_seg = 7'h00;
    case (i_hex)
      4'h0: o_seg = 7'h3F;
      4'h1: o_seg = 7'h06;
      4'h2: o_seg = 7'h5B;
      4'h3: o_seg = 7'h4F;
      4'h4: o_seg = 7'h66;
      4'h5: o_seg = 7'h6D;
      4'h6: o_seg = 7'h7D;
      4'h7: o_seg = 7'h07;
      4'h8: o_seg = 7'h7F;
      4'h9: o_seg = 7'h6F;
      4'hA: o_seg = 7'h77;
      4'hB: o_seg = 7'h7C;
      4'hC: o_seg = 7'h39;
      4'hD: o_seg = 7'h5E;
      4'hE: o_seg = 7'h79;
      4'hF: o_seg = 7'h71;
      default: o_seg = 7'h00;
    endcase
  end
endmodule
